// File: rtl/sweep_pkg.sv
// Shared types and the MISR step function for the sweep BIST controller.
package sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // The computation is done at 64 bits so that any signature width up to 64 can use it.
  // The caller truncates the result to its own width.
  function automatic logic [63:0] misr_step(input logic [63:0] sig,
                                            input logic [63:0] poly,
                                            input logic [63:0] din,
                                            input int unsigned width);
    logic [63:0] fb;
    fb = sig[width-1] ? poly : 64'd0;
    return (sig << 1) ^ fb ^ din;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// Multiple-input signature register: it loads the seed on load, then
// compresses din once per enabled cycle.
module sweep_misr
  import sweep_pkg::*;
#(
  parameter int               SIG_W    = 16,
  parameter int               DIN_W    = 6,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [SIG_W-1:0] seed,
  input  logic [DIN_W-1:0] din,
  output logic [SIG_W-1:0] sig
);

  // NOTE: registers are written with non-blocking assignments only, so every
  // flop samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= SIG_W'(misr_step(64'(sig), 64'(SIG_POLY), 64'(din), SIG_W));
    end
  end

endmodule

// File: rtl/sweep_bist.sv
// Exhaustive operand sweep generator (binary or Gray order). The DUT's
// responses are compacted into a MISR signature.
module sweep_bist
  import sweep_pkg::*;
#(
  parameter int                 A_W      = 5,
  parameter int                 B_W      = 5,
  parameter int                 Y_W      = 6,
  parameter int                 RESP_LAT = 0,
  parameter int                 SIG_W    = 16,
  parameter logic [SIG_W-1:0]   SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0]   SIG_SEED = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic                 hold,
  output logic [A_W-1:0]       a,
  output logic [B_W-1:0]       b,
  output logic                 vec_valid,
  input  logic [Y_W-1:0]       resp_in,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature,
  output logic [A_W+B_W:0]     vec_count
);

  localparam int           N     = A_W + B_W;
  localparam logic [N-1:0] LAST  = '1;
  localparam logic [N:0]   TOTAL = {1'b1, {N{1'b0}}};

  state_t       state;
  logic [N-1:0] index;
  logic [N-1:0] vec;
  logic         mode_q;
  logic         go;
  logic         vld_d;

  assign go        = start && (state == IDLE || state == DONE);
  assign vec_valid = (state == RUN) && !hold;
  assign vec       = mode_q ? (index ^ (index >> 1)) : index;
  assign a         = vec[A_W-1:0];
  assign b         = vec[N-1:A_W];
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  // The valid pipeline keeps shifting during hold. This lets responses already in flight still reach the MISR.
  if (RESP_LAT == 0) begin : g_no_pipe
    assign vld_d = vec_valid;
  end else begin : g_pipe
    logic [RESP_LAT-1:0] pipe;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe <= '0;
      else        pipe <= (pipe << 1) | RESP_LAT'(vec_valid);
    end
    assign vld_d = pipe[RESP_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      index     <= '0;
      mode_q    <= 1'b0;
      vec_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            index  <= '0;
            mode_q <= mode;
          end
        end
        RUN: begin
          if (vec_valid) begin
            index <= index + 1'b1;
            if (index == LAST) state <= (RESP_LAT == 0) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          // The absorption this cycle is the last one, so leave after this edge.
          if (vld_d && vec_count == TOTAL - 1'b1) state <= DONE;
        end
        default: state <= IDLE;
      endcase

      if (go)         vec_count <= '0;
      else if (vld_d) vec_count <= vec_count + 1'b1;
    end
  end

  sweep_misr #(
    .SIG_W   (SIG_W),
    .DIN_W   (Y_W),
    .SIG_POLY(SIG_POLY)
  ) u_misr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (go),
    .en   (vld_d),
    .seed (SIG_SEED),
    .din  (resp_in),
    .sig  (signature)
  );

endmodule

// File: tb/tb_sweep_bist.sv
// Directed bench for sweep_bist. u0 has a latency-0 response path. u1 has a
// latency-2 path to a registered a+b DUT.
module tb_sweep_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, mode = 1'b0, hold = 1'b0, use_sum = 1'b0;
  logic [1:0]  a0, b0, a1, b1;
  logic        vv0, vv1, busy0, busy1, done0, done1;
  logic [5:0]  resp0, resp1, r1, r2;
  logic [15:0] sig0, sig1;
  logic [4:0]  cnt0, cnt1;

  int tests = 0;
  int fails = 0;
  int busy_cnt, done_cyc;
  logic [3:0] seen[$];

  always #5 clk = ~clk;

  assign resp0 = use_sum ? (6'(a0) + 6'(b0)) : 6'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
    end else begin
      r1 <= 6'(a1) + 6'(b1);
      r2 <= r1;
    end
  end
  assign resp1 = r2;

  sweep_bist #(.A_W(2), .B_W(2), .Y_W(6), .RESP_LAT(0), .SIG_W(16),
               .SIG_POLY(16'h1021), .SIG_SEED(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode), .hold(hold),
    .a(a0), .b(b0), .vec_valid(vv0), .resp_in(resp0), .busy(busy0),
    .done(done0), .signature(sig0), .vec_count(cnt0));

  sweep_bist #(.A_W(2), .B_W(2), .Y_W(6), .RESP_LAT(2), .SIG_W(16),
               .SIG_POLY(16'h1021), .SIG_SEED(16'hFFFF)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .hold(hold),
    .a(a1), .b(b1), .vec_valid(vv1), .resp_in(resp1), .busy(busy1),
    .done(done1), .signature(sig1), .vec_count(cnt1));

  // Reference MISR over the binary order, with the response being either 0 or a+b.
  function automatic logic [15:0] model_sig(input logic [15:0] seed, input bit sum_on);
    logic [15:0] s;
    logic [3:0]  v;
    logic [5:0]  r;
    s = seed;
    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      r = sum_on ? ({4'b0, v[1:0]} + {4'b0, v[3:2]}) : 6'd0;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {10'd0, r};
    end
    return s;
  endfunction

  // Starts a sweep on u0 (sel=0) or u1 (sel=1). It then samples once per cycle until done is seen or the 60-cycle bound runs out.
  task automatic run(input bit sel, input logic m, input int hold_at,
                     input int hold_len, input int restart_at);
    seen.delete();
    busy_cnt = 0;
    done_cyc = 0;
    @(negedge clk);
    mode = m;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      hold = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      if (sel) start1 = (cyc == restart_at); else start0 = (cyc == restart_at);
      #1;
      if (sel ? busy1 : busy0) busy_cnt++;
      if (sel ? vv1 : vv0) seen.push_back(sel ? {b1, a1} : {b0, a0});
      if (sel ? done1 : done0) done_cyc = cyc;
      else @(negedge clk);
    end
    hold = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    tests++;
    if ({a0, b0, vv0, busy0, done0} !== 7'b0) begin
      fails++; $display("FAIL reset_ctl0: got %b expected 0", {a0, b0, vv0, busy0, done0});
    end
    tests++;
    if ({sig0, cnt0} !== 21'b0) begin
      fails++; $display("FAIL reset_sig0: got %h expected 0", {sig0, cnt0});
    end
    tests++;
    if ({a1, b1, vv1, busy1, done1, sig1, cnt1} !== 28'b0) begin
      fails++; $display("FAIL reset_u1: got %h expected 0", {a1, b1, vv1, busy1, done1, sig1, cnt1});
    end
  endtask

  task automatic test_binary;
    logic [3:0] exp_v[5];
    exp_v = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    use_sum = 1'b0;
    run(1'b0, 1'b0, 0, 0, 0);
    tests++;
    if (seen.size() != 16) begin
      fails++; $display("FAIL bin_valid_cycles: got %0d expected 16", seen.size());
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (seen.size() <= i || seen[i] !== exp_v[i]) begin
        fails++; $display("FAIL bin_vec%0d: got %h expected %h", i, (seen.size() > i) ? seen[i] : 4'hx, exp_v[i]);
      end
    end
    tests++;
    if (done_cyc != 17) begin
      fails++; $display("FAIL bin_done_cycle: got %0d expected 17", done_cyc);
    end
    tests++;
    if (busy_cnt != 16) begin
      fails++; $display("FAIL bin_busy: got %0d expected 16", busy_cnt);
    end
    tests++;
    if (cnt0 !== 5'd16 || sig0 !== 16'h0000) begin
      fails++; $display("FAIL bin_result: got cnt=%0d sig=%h expected cnt=16 sig=0000", cnt0, sig0);
    end
  endtask

  task automatic test_gray;
    logic [3:0] exp_v[9];
    exp_v = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    use_sum = 1'b0;
    run(1'b0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tests++;
      if (seen.size() <= i || seen[i] !== exp_v[i]) begin
        fails++; $display("FAIL gray_vec%0d: got %h expected %h", i, (seen.size() > i) ? seen[i] : 4'hx, exp_v[i]);
      end
    end
    tests++;
    if (seen.size() != 16 || seen[15] !== 4'd8) begin
      fails++; $display("FAIL gray_last: got n=%0d expected n=16 last=8", seen.size());
    end
    tests++;
    if (done_cyc != 17 || cnt0 !== 5'd16) begin
      fails++; $display("FAIL gray_done: got cyc=%0d cnt=%0d expected 17/16", done_cyc, cnt0);
    end
  endtask

  task automatic test_sum_lat0;
    use_sum = 1'b1;
    run(1'b0, 1'b0, 0, 0, 0);
    tests++;
    if (sig0 !== model_sig(16'h0000, 1'b1) || cnt0 !== 5'd16) begin
      fails++; $display("FAIL sum_sig: got sig=%h cnt=%0d expected sig=%h cnt=16", sig0, cnt0, model_sig(16'h0000, 1'b1));
    end
  endtask

  task automatic test_hold;
    use_sum = 1'b1;
    run(1'b0, 1'b0, 5, 3, 0);
    tests++;
    if (busy_cnt != 19 || done_cyc != 20) begin
      fails++; $display("FAIL hold_busy: got busy=%0d done=%0d expected 19/20", busy_cnt, done_cyc);
    end
    tests++;
    if (sig0 !== model_sig(16'h0000, 1'b1) || cnt0 !== 5'd16) begin
      fails++; $display("FAIL hold_sig: got sig=%h cnt=%0d expected sig=%h cnt=16", sig0, cnt0, model_sig(16'h0000, 1'b1));
    end
    tests++;
    if (seen.size() != 16 || seen[4] !== 4'd4 || seen[15] !== 4'd15) begin
      fails++; $display("FAIL hold_order: got n=%0d expected 16 in binary order", seen.size());
    end
  endtask

  task automatic test_start_ignored;
    use_sum = 1'b1;
    run(1'b0, 1'b0, 0, 0, 6);
    tests++;
    if (done_cyc != 17 || cnt0 !== 5'd16 || sig0 !== model_sig(16'h0000, 1'b1)) begin
      fails++; $display("FAIL start_busy: got cyc=%0d cnt=%0d sig=%h expected 17/16/%h", done_cyc, cnt0, sig0, model_sig(16'h0000, 1'b1));
    end
  endtask

  task automatic test_back_to_back;
    use_sum = 1'b0;
    run(1'b0, 1'b0, 0, 0, 0);
    tests++;
    if (done_cyc != 17 || sig0 !== 16'h0000 || cnt0 !== 5'd16) begin
      fails++; $display("FAIL b2b_restart: got cyc=%0d sig=%h cnt=%0d expected 17/0000/16", done_cyc, sig0, cnt0);
    end
  endtask

  task automatic test_reset_mid;
    bit hit;
    hit = 1'b0;
    use_sum = 1'b1;
    @(negedge clk);
    mode = 1'b0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      #1;
      if (vv0 && {b0, a0} == 4'd7) hit = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++; $display("FAIL rst_reach_idx7: got no index 7 expected index 7 within 40 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({a0, b0, vv0, busy0, done0, sig0, cnt0} !== 28'b0) begin
      fails++; $display("FAIL rst_async: got %h expected 0", {a0, b0, vv0, busy0, done0, sig0, cnt0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 5'd0) begin
      fails++; $display("FAIL rst_no_resume: got busy=%b done=%b cnt=%0d expected 0/0/0", busy0, done0, cnt0);
    end
    run(1'b0, 1'b0, 0, 0, 0);
    tests++;
    if (sig0 !== model_sig(16'h0000, 1'b1) || cnt0 !== 5'd16) begin
      fails++; $display("FAIL rst_rerun_sig: got sig=%h cnt=%0d expected %h/16", sig0, cnt0, model_sig(16'h0000, 1'b1));
    end
  endtask

  task automatic test_lat2;
    run(1'b1, 1'b0, 0, 0, 0);
    tests++;
    if (done_cyc != 19) begin
      fails++; $display("FAIL lat2_done_cycle: got %0d expected 19", done_cyc);
    end
    tests++;
    if (busy_cnt != 18 || seen.size() != 16) begin
      fails++; $display("FAIL lat2_busy: got busy=%0d valid=%0d expected 18/16", busy_cnt, seen.size());
    end
    tests++;
    if (sig1 !== model_sig(16'hFFFF, 1'b1) || cnt1 !== 5'd16) begin
      fails++; $display("FAIL lat2_sig: got sig=%h cnt=%0d expected %h/16", sig1, cnt1, model_sig(16'hFFFF, 1'b1));
    end
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_binary;
    test_gray;
    test_sum_lat0;
    test_hold;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    test_lat2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
